song_sequencer: RTL

- Upstream feeder for the Sound tone generator.
- Walks a song stored in an external synchronous ROM, one note record at a time.
- Drives Sound's en/octave/note/length/full_note, and uses Sound's `over` to advance to the next record.
- Provides play/pause/stop control, a short articulation gap between notes, and end-of-song signalling.

---
 rtl/song_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/song_sequencer.sv
// song_sequencer
//   Upstream feeder for the Sound tone generator. Walks a song held in an
//   external synchronous ROM one note record at a time, drives Sound's
//   en/octave/note/length/full_note and advances when Sound raises `over`.
//   Offers play/pause/stop control, an articulation gap between notes and
//   end-of-song signalling.
//
//   Record layout (MSB..LSB): {end, octave, note, length, full_note}.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     play              pulse: (re)start song song_sel from record 0
//     stop              pulse: abort to idle
//     pause             level: hold playback while high
//     song_sel          song slot, sampled on play
//     rom_addr          {song, index} to the ROM
//     rom_data          record, valid one cycle after rom_addr
//     over              note-finished flag from Sound
//     snd_*             note controls to Sound
//     busy              high in any state except idle/done
//     done              one-cycle pulse on natural song end
//     note_idx          index of the current record
//
//   Optional build macro: SEQ_LOOP_EN -- an end record or index exhaustion
//   restarts the song from record 0 (done still pulses once per pass)
//   instead of stopping.
module song_sequencer #(
  parameter int unsigned OCT_W      = 3,
  parameter int unsigned NOTE_W     = 3,
  parameter int unsigned LEN_W      = 3,
  parameter int unsigned FULL_W     = 2,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned SONG_AW    = 6,
  parameter int unsigned GAP_CYCLES = 2000000
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   play,
  input  logic                                   stop,
  input  logic                                   pause,
  input  logic [SEL_W-1:0]                       song_sel,
  output logic [SEL_W+SONG_AW-1:0]               rom_addr,
  input  logic [OCT_W+NOTE_W+LEN_W+FULL_W:0]     rom_data,
  input  logic                                   over,
  output logic                                   snd_en,
  output logic [OCT_W-1:0]                       snd_octave,
  output logic [NOTE_W-1:0]                      snd_note,
  output logic [LEN_W-1:0]                       snd_length,
  output logic [FULL_W-1:0]                      snd_full_note,
  output logic                                   busy,
  output logic                                   done,
  output logic [SONG_AW-1:0]                     note_idx
);

  localparam int unsigned REC_W    = 1 + OCT_W + NOTE_W + LEN_W + FULL_W;
  localparam int unsigned LEN_LSB  = FULL_W;
  localparam int unsigned NOTE_LSB = FULL_W + LEN_W;
  localparam int unsigned OCT_LSB  = FULL_W + LEN_W + NOTE_W;

  localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SONG_AW-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_ARM,
    S_PLAY,
    S_PAUSED,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    song_q;
  logic [SONG_AW-1:0]  idx_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic                done_q;

  logic rec_end;
  logic load_fields, idx_inc, idx_clr, song_load, gap_load, gap_dec, end_song;

  assign rec_end = rom_data[REC_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_fields = 1'b0;
    idx_inc     = 1'b0;
    idx_clr     = 1'b0;
    song_load   = 1'b0;
    gap_load    = 1'b0;
    gap_dec     = 1'b0;
    end_song    = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      idx_clr = 1'b1;
    end else if (play) begin
      state_d   = S_FETCH;
      idx_clr   = 1'b1;
      song_load = 1'b1;
    end else begin
      unique case (state_q)
        S_FETCH:    state_d = S_WAIT_ROM;
        S_WAIT_ROM: begin
          if (rec_end) begin
            end_song = 1'b1;
          end else begin
            load_fields = 1'b1;
            // A pause raised before the note starts parks here, so Sound
            // never sees a one-cycle enable blip.
            state_d = pause ? S_PAUSED : S_ARM;
          end
        end
        S_ARM: begin
          // Sound's over is stale in the first enabled cycle; wait for it
          // to clear before watching for the note end.
          if (pause)      state_d = S_PAUSED;
          else if (!over) state_d = S_PLAY;
        end
        S_PLAY: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (over) begin
            // The last slot index never wraps into the next song.
            if (idx_q == IDX_LAST) begin
              end_song = 1'b1;
            end else begin
              idx_inc  = 1'b1;
              gap_load = 1'b1;
              state_d  = (GAP_CYCLES > 0) ? S_GAP : S_FETCH;
            end
          end
        end
        S_PAUSED: if (!pause) state_d = S_ARM;
        S_GAP: begin
          if (gap_cnt == '0) state_d = S_FETCH;
          else               gap_dec = 1'b1;
        end
        default: ;
      endcase

      if (end_song) begin
`ifdef SEQ_LOOP_EN
        idx_clr = 1'b1;
        state_d = S_FETCH;
`else
        state_d = S_DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q        <= '0;
      idx_q         <= '0;
      gap_cnt       <= '0;
      done_q        <= 1'b0;
      snd_octave    <= '0;
      snd_note      <= '0;
      snd_length    <= '0;
      snd_full_note <= '0;
    end else begin
      done_q <= end_song;
      if (song_load) song_q <= song_sel;
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + SONG_AW'(1);
      if (gap_load)     gap_cnt <= GAP_LOAD;
      else if (gap_dec) gap_cnt <= gap_cnt - GAP_W'(1);
      if (load_fields) begin
        snd_octave    <= rom_data[OCT_LSB  +: OCT_W];
        snd_note      <= rom_data[NOTE_LSB +: NOTE_W];
        snd_length    <= rom_data[LEN_LSB  +: LEN_W];
        snd_full_note <= rom_data[0        +: FULL_W];
      end
    end
  end

  // Enable is decoded from the state register so an async reset or a stop
  // drops it without waiting on a separate flop.
  assign snd_en   = (state_q == S_ARM) || (state_q == S_PLAY);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = done_q;
  assign rom_addr = {song_q, idx_q};
  assign note_idx = idx_q;

endmodule
